// File: rtl/sdram_arbiter.sv
// Shares one Avalon-MM SDRAM master between a read and a write requester.
// Reads are favoured for at most READ_BURST grants while a write is waiting.
module sdram_arbiter #(
    parameter int ADDR_WIDTH  = 24,
    parameter int DATA_WIDTH  = 32,
    parameter int MAX_PENDING = 16,
    parameter int READ_BURST  = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  rd_req,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic                  rd_ack,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    input  logic                  wr_req,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  wr_ack,
    output logic [ADDR_WIDTH-1:0] sdaddress,
    output logic                  sdread,
    output logic                  sdwrite,
    output logic [DATA_WIDTH-1:0] sdwritedata,
    input  logic [DATA_WIDTH-1:0] sdreaddata,
    input  logic                  sdreaddatavalid,
    input  logic                  sdwaitrequest,
    output logic [7:0]            pending,
    output logic [7:0]            spurious
);

    typedef enum logic [1:0] {IDLE, READ, WRITE, ACK} state_t;

    localparam logic [7:0] MAX_PEND_L = 8'(MAX_PENDING);
    localparam logic [7:0] BURST_L    = 8'(READ_BURST);

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] sdaddress_q, sdaddress_d;
    logic                  sdread_q, sdread_d;
    logic                  sdwrite_q, sdwrite_d;
    logic [DATA_WIDTH-1:0] sdwritedata_q, sdwritedata_d;
    logic                  rd_ack_q, rd_ack_d;
    logic                  wr_ack_q, wr_ack_d;
    logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
    logic                  rd_valid_q, rd_valid_d;
    logic [7:0]            pending_q, pending_d;
    logic [7:0]            spurious_q, spurious_d;
    logic [7:0]            rd_run_q, rd_run_d;

    logic rd_elig;
    logic rd_accept;
    logic rd_return;

    assign rd_elig   = rd_req && (pending_q < MAX_PEND_L);
    assign rd_accept = (state_q == READ) && !sdwaitrequest;
    assign rd_return = sdreaddatavalid && (pending_q != 8'd0);

    always_comb begin
        state_d       = state_q;
        sdaddress_d   = sdaddress_q;
        sdread_d      = sdread_q;
        sdwrite_d     = sdwrite_q;
        sdwritedata_d = sdwritedata_q;
        rd_ack_d      = 1'b0;
        wr_ack_d      = 1'b0;
        rd_run_d      = rd_run_q;
        rd_data_d     = sdreaddata;
        rd_valid_d    = sdreaddatavalid;
        pending_d     = pending_q;
        spurious_d    = spurious_q;

        case (state_q)
            IDLE: begin
                // rd_run counts only reads granted while a write is waiting
                if (!wr_req) begin
                    rd_run_d = 8'd0;
                end
                if (rd_elig && (!wr_req || rd_run_q < BURST_L)) begin
                    sdaddress_d = rd_addr;
                    sdread_d    = 1'b1;
                    state_d     = READ;
                    if (wr_req) begin
                        rd_run_d = rd_run_q + 8'd1;
                    end
                end else if (wr_req) begin
                    sdaddress_d   = wr_addr;
                    sdwritedata_d = wr_data;
                    sdwrite_d     = 1'b1;
                    rd_run_d      = 8'd0;
                    state_d       = WRITE;
                end
            end
            READ: begin
                if (!sdwaitrequest) begin
                    sdread_d = 1'b0;
                    rd_ack_d = 1'b1;
                    state_d  = ACK;
                end
            end
            WRITE: begin
                if (!sdwaitrequest) begin
                    sdwrite_d = 1'b0;
                    wr_ack_d  = 1'b1;
                    state_d   = ACK;
                end
            end
            ACK: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (rd_accept && !rd_return) begin
            pending_d = pending_q + 8'd1;
        end else if (!rd_accept && rd_return) begin
            pending_d = pending_q - 8'd1;
        end

        // Data with nothing outstanding is still forwarded, just counted
        if (sdreaddatavalid && (pending_q == 8'd0) && (spurious_q != 8'hFF)) begin
            spurious_d = spurious_q + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            sdaddress_q   <= '0;
            sdread_q      <= 1'b0;
            sdwrite_q     <= 1'b0;
            sdwritedata_q <= '0;
            rd_ack_q      <= 1'b0;
            wr_ack_q      <= 1'b0;
            rd_data_q     <= '0;
            rd_valid_q    <= 1'b0;
            pending_q     <= 8'd0;
            spurious_q    <= 8'd0;
            rd_run_q      <= 8'd0;
        end else begin
            state_q       <= state_d;
            sdaddress_q   <= sdaddress_d;
            sdread_q      <= sdread_d;
            sdwrite_q     <= sdwrite_d;
            sdwritedata_q <= sdwritedata_d;
            rd_ack_q      <= rd_ack_d;
            wr_ack_q      <= wr_ack_d;
            rd_data_q     <= rd_data_d;
            rd_valid_q    <= rd_valid_d;
            pending_q     <= pending_d;
            spurious_q    <= spurious_d;
            rd_run_q      <= rd_run_d;
        end
    end

    assign sdaddress   = sdaddress_q;
    assign sdread      = sdread_q;
    assign sdwrite     = sdwrite_q;
    assign sdwritedata = sdwritedata_q;
    assign rd_ack      = rd_ack_q;
    assign wr_ack      = wr_ack_q;
    assign rd_data     = rd_data_q;
    assign rd_valid    = rd_valid_q;
    assign pending     = pending_q;
    assign spurious    = spurious_q;

endmodule

// File: doc/sdram_arbiter.md
# sdram_arbiter

Two-port arbiter that shares the single Avalon-MM SDRAM master between a read requester (sample fetch) and a write requester (filtered-result store) in the notch-filter streaming datapath. Latches one request at a time, drives the master until accepted, tracks outstanding pipelined reads, and returns read data in order. Bounded read-priority scheduling keeps the write path from starving while the calculation pipeline is fed.

## Interface
- ADDR_WIDTH, 24, SDRAM word address width
- DATA_WIDTH, 32, data bus width
- MAX_PENDING, 16, maximum outstanding (accepted, not yet returned) reads; power of two, ≤ 255
- READ_BURST, 4, maximum consecutive read grants while wr_req is pending

- clk  in  1  clock, all logic on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- rd_req  in  1  read request; held with rd_addr until rd_ack
- rd_addr  in  ADDR_WIDTH  read address
- rd_ack  out  1  one-cycle pulse: read accepted by SDRAM
- rd_data  out  DATA_WIDTH  returned read data
- rd_valid  out  1  rd_data valid, one cycle per word
- wr_req  in  1  write request; held with wr_addr/wr_data until wr_ack
- wr_addr  in  ADDR_WIDTH  write address
- wr_data  in  DATA_WIDTH  write data
- wr_ack  out  1  one-cycle pulse: write accepted
- sdaddress  out  ADDR_WIDTH  Avalon master address
- sdread  out  1  Avalon read
- sdwrite  out  1  Avalon write
- sdwritedata  out  DATA_WIDTH  Avalon write data
- sdreaddata  in  DATA_WIDTH  Avalon read data
- sdreaddatavalid  in  1  Avalon read data valid
- sdwaitrequest  in  1  Avalon wait request
- pending  out  8  outstanding read count
- spurious  out  8  saturating count of readdatavalid with pending == 0

## Operation
- All outputs registered; reset value of every output is 0.
- States: IDLE, READ, WRITE, ACK.
- IDLE: read eligible = rd_req && pending < MAX_PENDING (counting any acceptance this cycle). Write eligible = wr_req.
  - Both eligible: grant read if rd_run < READ_BURST, else write.
  - One eligible: grant it. None: stay.
  - Read grant: sdaddress ← rd_addr, sdread ← 1, rd_run ← rd_run+1 (saturate at READ_BURST), → READ.
  - Write grant: sdaddress ← wr_addr, sdwritedata ← wr_data, sdwrite ← 1, rd_run ← 0, → WRITE.
  - rd_run also clears to 0 whenever wr_req is low in IDLE.
- READ: hold sdread/sdaddress while sdwaitrequest=1. On sdwaitrequest=0: sdread ← 0, rd_ack ← 1, pending +1, → ACK.
- WRITE: hold sdwrite/sdaddress/sdwritedata while sdwaitrequest=1. On sdwaitrequest=0: sdwrite ← 0, wr_ack ← 1, → ACK.
- ACK: ack pulse visible this cycle; no arbitration (requester updates req/addr); acks cleared; → IDLE.
- Read return: independent of state. rd_data ← sdreaddata, rd_valid ← sdreaddatavalid every cycle. pending −1 on each valid when pending > 0.
- Simultaneous read acceptance and readdatavalid: pending unchanged.
- readdatavalid with pending = 0: data still forwarded, pending stays 0, spurious +1 (saturates at 255).
- sdread and sdwrite never high together.

## Timing
- Grant at edge ending IDLE cycle t → sdread/sdwrite high in cycle t+1.
- Accept at edge ending cycle a (sdwaitrequest=0) → ack high cycle a+1 (ACK), IDLE cycle a+2; earliest next grant at edge ending a+2, master active a+3. Zero-wait transaction period: 3 cycles.
- Read data latency: rd_valid exactly 1 cycle after sdreaddatavalid; order preserved.
- pending reaches MAX_PENDING: no read grant until a valid returns; writes still granted.
- Reset asserted mid-transaction: sdread/sdwrite, acks, pending, rd_run, spurious drop to 0 immediately (async); FSM → IDLE; in-flight read returns after reset counted as spurious.

## Test plan
- Single read, sdwaitrequest low: rd_req, rd_addr=0x000100 → sdread+sdaddress=0x000100 one cycle, rd_ack one cycle later, pending=1; readdatavalid with 0x0000007F → rd_data=0x7F, rd_valid next cycle, pending=0.
- Wait-state hold: write 0x000200/0xFFFFFF85 with sdwaitrequest high 5 cycles → sdwrite, address, data stable 6 cycles, wr_ack one pulse after release.
- Fairness: rd_req and wr_req held continuously, READ_BURST=4 → grant order R,R,R,R,W,R,R,R,R,W; no starvation.
- Pending cap: MAX_PENDING=16, no readdatavalid → 16 rd_acks then sdread stays low, pending=16; a write request still granted; one valid → pending=15, next read granted.
- Simultaneous accept+valid at pending=3 → pending stays 3; valid at pending=0 → spurious=1, rd_valid still pulses.
- Reset during READ with sdwaitrequest high → sdread 0 same cycle as reset, pending 0, no rd_ack after reset deasserts.
